regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised architectural register file for the RV32I core. It provides NRD combinational read ports and one synchronous write port, with a hardwired-zero register option. A sequential clear engine zeroes the array after reset or on request; the core stalls on `ready`. It replaces the fixed 2-read / 32×32 file in the decode stage and adds same-cycle write-to-read bypass as a build option.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `AW`, 5, register address width; depth `NREGS = 2**AW`.
- `NRD`, 2, number of read ports (≥1).
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes; when 0 it is an ordinary register.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clr` in 1: synchronous request to re-zero the whole file.
- `ready` out 1: file usable; writes accepted only when 1.
- `reg_write` in 1: write enable.
- `rd` in AW: write address.
- `write_data` in XLEN: write data.
- `rs` in NRD*AW: read addresses; port k is `rs[k*AW +: AW]`.
- `read_data` out NRD*XLEN: read data; port k is `read_data[k*XLEN +: XLEN]`.
- `wr_drop` out 1: registered pulse, 1 cycle after a write request was refused.

## Operation
- State machine with two states, CLEAR and READY. There is an AW-bit sweep counter `cnt`.
- `rst` asserted, asynchronously: state=CLEAR, cnt=0, wr_drop=0. `ready`=0 combinationally from state. The array itself is not reset asynchronously.
- CLEAR, each rising edge:
  - writes 0 to `reg[cnt]`;
  - increments cnt;
  - when cnt==NREGS-1, moves to READY on that same edge.
- READY, rising edge with `clr`=1: moves to CLEAR with cnt=0. `clr` has priority over a same-cycle write; that write is dropped.
- `clr` while in CLEAR: ignored; the sweep continues and is not restarted.
- Write commits on a rising edge only when all of these hold:
  - state==READY;
  - `clr`=0;
  - `reg_write`=1;
  - not (ZERO_REG==1 and rd==0).
- `wr_drop` is set on the next edge when `reg_write`=1 and the write was refused because state was CLEAR or `clr` was 1. Writes to x0 with ZERO_REG=1 do not set `wr_drop`.
- Reads are combinational, with this priority:
  - state CLEAR: 0;
  - ZERO_REG==1 and rs==0: 0;
  - otherwise `reg[rs]`, subject to bypass (see Configuration).
- All NRD ports are independent. Identical addresses on several ports return identical data.

## Timing
- Reset values: `ready`=0, `wr_drop`=0, all `read_data`=0.
- After `rst` deasserts, `ready` rises after exactly NREGS rising edges (32 with defaults). The whole array is 0 at that point.
- `clr` sampled high in READY: `ready` falls after that edge. It returns NREGS edges later.
- Write latency: a committed write is visible on read ports after the commit edge. With bypass it is also visible in the same cycle.
- `rst` asserted mid-sweep or mid-operation: immediately back to CLEAR, cnt=0. The full NREGS-cycle sweep repeats.
- cnt wraps naturally at NREGS-1 → 0; no extra terminal cycle.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: in READY, if a write commits this cycle and its `rd` equals port k's address, `read_data` port k returns `write_data` combinationally in the same cycle. This applies per port. It never applies to x0 when ZERO_REG=1, nor when the write is refused.
- Undefined: the read returns the old contents until after the commit edge. This is write-after-read ordering; the core must schedule writeback accordingly.

## Test plan
- Reset sweep: assert `rst` 3 cycles, then release. `ready` must rise on exactly the 32nd edge; x1..x31 must read 0 on all ports.
- Write/read: write x5=0xDEADBEEF, then x31=0x12345678. Both ports must read these values on the next cycle; x0 write of 0xFFFFFFFF must still read 0.
- Bypass: in one cycle, write x7=0xA5A5A5A5 with rs0=7, rs1=7.
  - With `REGFILE_BYPASS_EN`: both ports return 0xA5A5A5A5 in that cycle.
  - Without it: both return the prior value, then 0xA5A5A5A5 on the next cycle.
- Clear with collision: load x3=0x1, then pulse `clr` together with a write x4=0x2. Expect `wr_drop`=1 on the next cycle, `ready` low for 32 cycles, and x3 and x4 both reading 0 afterwards.
- Write during sweep: `reg_write`=1 to x9 while `ready`=0. Expect `wr_drop` pulses and x9 reads 0 after `ready` rises.
- Async reset mid-sweep: assert `rst` for less than one clock period at sweep cycle 10. Outputs must reset immediately, and `ready` must rise exactly 32 edges after release.

Source files
------------

// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if
// Bus between the core's decode/writeback logic and the register file.
//   clr        : request to re-zero the whole file
//   ready      : file usable; writes accepted only while high
//   reg_write  : write enable
//   rd         : write address
//   write_data : write data
//   rs         : packed read addresses, port k = rs[k*AW +: AW]
//   read_data  : packed read data, port k = read_data[k*XLEN +: XLEN]
//   wr_drop    : one-cycle pulse after a write request was refused
// Modports: master = core side, slave = register file side.
interface regfile_multiport_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
);
    logic                  clr;
    logic                  ready;
    logic                  reg_write;
    logic [AW-1:0]         rd;
    logic [XLEN-1:0]       write_data;
    logic [NRD*AW-1:0]     rs;
    logic [NRD*XLEN-1:0]   read_data;
    logic                  wr_drop;

    modport master (
        output clr, reg_write, rd, write_data, rs,
        input  ready, read_data, wr_drop
    );

    modport slave (
        input  clr, reg_write, rd, write_data, rs,
        output ready, read_data, wr_drop
    );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport
// Architectural register file for the RV32I core: NRD combinational read
// ports, one synchronous write port, optional hardwired-zero x0. A sequential
// sweep zeroes the array after reset or on a clr request; ready stays low
// while the sweep runs and writes issued then are refused (wr_drop pulses).
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : regfile_multiport_if.slave (clr, ready, reg_write, rd, write_data,
//         rs, read_data, wr_drop)
//
// Build option: define REGFILE_BYPASS_EN to forward a committing write to any
// read port addressing the same register in the same cycle. Without it a
// read returns the old contents until after the commit edge.
module regfile_multiport #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_multiport_if.slave   bus
);
    localparam int NREGS = 2 ** AW;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            wr_drop_q, wr_drop_d;

    logic [XLEN-1:0] regs [NREGS];

    logic rd_is_x0;
    logic write_req;
    logic we_commit;

    // With a hardwired x0, a write to it is neither committed nor reported as
    // dropped: it is simply a no-op.
    assign rd_is_x0  = (ZERO_REG != 0) && (bus.rd == '0);
    assign write_req = bus.reg_write && !rd_is_x0;
    // clr wins over a same-cycle write.
    assign we_commit = write_req && (state_q == READY) && !bus.clr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_drop_d = write_req && ((state_q == CLEAR) || bus.clr);
        unique case (state_q)
            CLEAR: begin
                // clr is ignored here; the sweep runs to completion.
                cnt_d = cnt_q + AW'(1);
                if (&cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: the array has no reset; the CLEAR sweep zeroes it one entry per
    // cycle, and reads are forced to 0 until the sweep completes.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            regs[cnt_q] <= '0;
        end else if (we_commit) begin
            regs[bus.rd] <= bus.write_data;
        end
    end

    assign bus.ready   = (state_q == READY);
    assign bus.wr_drop = wr_drop_q;

    for (genvar k = 0; k < NRD; k++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = bus.rs[k*AW +: AW];

        always_comb begin
            data = '0;
            if ((state_q == READY) && !((ZERO_REG != 0) && (addr == '0))) begin
                data = regs[addr];
`ifdef REGFILE_BYPASS_EN
                // we_commit already excludes refused writes and x0.
                if (we_commit && (bus.rd == addr)) begin
                    data = bus.write_data;
                end
`endif
            end
        end

        assign bus.read_data[k*XLEN +: XLEN] = data;
    end
endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport
// Directed stimulus for regfile_multiport with default parameters. Stimulus
// pushes expected values tagged with the cycle they apply to; a monitor pops
// and compares them on the falling edge of that cycle.
module tb_regfile_multiport;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    localparam int SIG_RD    = 0;
    localparam int SIG_READY = 1;
    localparam int SIG_DROP  = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        string       name;
        int          sig;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t exp_q[$];

    regfile_multiport_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

    regfile_multiport #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic push(input string name, input int sig, input int port,
                        input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.sig  = sig;
        e.port = port;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic exp_rd(input string name, input logic [31:0] v0,
                          input logic [31:0] v1);
        push({name, "_p0"}, SIG_RD, 0, v0);
        push({name, "_p1"}, SIG_RD, 1, v1);
    endtask

    task automatic exp_ready(input string name, input bit v);
        push(name, SIG_READY, 0, {31'd0, v});
    endtask

    task automatic exp_drop(input string name, input bit v);
        push(name, SIG_DROP, 0, {31'd0, v});
    endtask

    task automatic set_rs(input int p0, input int p1);
        bus.rs = {AW'(p1), AW'(p0)};
    endtask

    task automatic set_wr(input bit we, input int a, input logic [31:0] d);
        bus.reg_write  = we;
        bus.rd         = AW'(a);
        bus.write_data = d;
    endtask

    // Counts edges of a sweep: ready must be low until exactly the 32nd.
    task automatic sweep_check(input string name);
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_ready($sformatf("%s_e%0d", name, i), i == 32);
        end
    endtask

    // Monitor: compares every expectation due in the current cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                n_checks = n_checks + 1;
                case (e.sig)
                    SIG_RD:    act = bus.read_data[e.port*XLEN +: XLEN];
                    SIG_READY: act = {31'd0, bus.ready};
                    default:   act = {31'd0, bus.wr_drop};
                endcase
                if (e.cyc != cyc) begin
                    $display("FAIL %s: not sampled in cycle %0d (now %0d)",
                             e.name, e.cyc, cyc);
                end else if (act === e.val) begin
                    n_pass = n_pass + 1;
                end else begin
                    $display("FAIL %s: got 0x%08h, expected 0x%08h",
                             e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b0;
        bus.clr  = 1'b0;
        set_wr(1'b0, 0, 32'h0);
        set_rs(0, 0);
        #1 rst = 1'b1;

        // Reset state, held for three cycles.
        tick();
        exp_ready("rst_ready", 1'b0);
        exp_drop("rst_drop", 1'b0);
        exp_rd("rst_rd", 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        sweep_check("sweep_init");

        // Whole file reads zero after the initial sweep.
        for (int r = 1; r < 32; r++) begin
            set_rs(r, r);
            exp_rd($sformatf("init_x%0d", r), 32'h0, 32'h0);
            tick();
        end

        // Write/read.
        set_wr(1'b1, 5, 32'hDEADBEEF);
        tick();
        set_wr(1'b1, 31, 32'h12345678);
        set_rs(5, 5);
        exp_rd("x5", 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        set_wr(1'b0, 0, 32'h0);
        set_rs(31, 31);
        exp_rd("x31", 32'h12345678, 32'h12345678);
        tick();
        set_rs(5, 31);
        exp_rd("x5_x31", 32'hDEADBEEF, 32'h12345678);
        tick();
        set_wr(1'b1, 0, 32'hFFFFFFFF);
        set_rs(0, 0);
        exp_rd("x0_same", 32'h0, 32'h0);
        tick();
        set_wr(1'b0, 0, 32'h0);
        exp_rd("x0_after", 32'h0, 32'h0);
        exp_drop("x0_no_drop", 1'b0);
        tick();

        // Same-cycle write/read of x7.
        set_wr(1'b1, 7, 32'hA5A5A5A5);
        set_rs(7, 7);
        exp_rd("byp_same", BYP ? 32'hA5A5A5A5 : 32'h0,
                           BYP ? 32'hA5A5A5A5 : 32'h0);
        tick();
        set_wr(1'b0, 0, 32'h0);
        exp_rd("byp_next", 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick();

        // clr colliding with a write to x4.
        set_wr(1'b1, 3, 32'h1);
        tick();
        set_wr(1'b1, 4, 32'h2);
        bus.clr = 1'b1;
        set_rs(3, 4);
        exp_rd("clr_cycle", 32'h1, 32'h0);
        exp_ready("clr_cycle_ready", 1'b1);
        tick();
        bus.clr = 1'b0;
        set_wr(1'b0, 0, 32'h0);
        exp_drop("clr_drop", 1'b1);
        exp_ready("clr_ready_low", 1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            exp_ready($sformatf("clr_sweep_e%0d", i), i == 32);
            if (i == 1) exp_drop("clr_drop_end", 1'b0);
        end
        exp_rd("clr_x3_x4", 32'h0, 32'h0);
        tick();

        // Write to x9 during a sweep, after the sweep passed x9.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 20) set_wr(1'b1, 9, 32'h99);
            tick();
            set_wr(1'b0, 0, 32'h0);
            exp_ready($sformatf("wsweep_e%0d", i), i == 32);
            if (i == 20) exp_drop("wsweep_drop", 1'b1);
            if (i == 21) exp_drop("wsweep_drop_end", 1'b0);
        end
        set_rs(9, 9);
        exp_rd("wsweep_x9", 32'h0, 32'h0);
        tick();

        // Short asynchronous reset at sweep cycle 10, while wr_drop is high.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) set_wr(1'b1, 9, 32'h77);
            tick();
            set_wr(1'b0, 0, 32'h0);
            if (i < 10) exp_ready($sformatf("arst_pre_e%0d", i), 1'b0);
        end
        #2 rst = 1'b1;
        exp_drop("arst_drop", 1'b0);
        exp_ready("arst_ready", 1'b0);
        exp_rd("arst_rd", 32'h0, 32'h0);
        #4 rst = 1'b0;
        sweep_check("arst_sweep");
        set_rs(5, 31);
        exp_rd("final_cleared", 32'h0, 32'h0);
        tick();
        tick();

        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks = n_checks + 1;
            $display("FAIL %s: expectation never sampled (cycle %0d)",
                     e.name, e.cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
